// File: rtl/hv_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// hd_mem_pkg
// Shared types and default sizing for the hypervector memory arbiter.
//   arb_state_e : arbiter FSM states (ARB = open round-robin, LOCKED = owner only)
//   DEF_*       : default parameter values used by hv_mem_arbiter
// -----------------------------------------------------------------------------
package hd_mem_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LOCK_MAX   = 16;

endpackage

// File: rtl/hv_mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Pure combinational round-robin picker. Scans the eligible mask starting at
// the pointer and wrapping modulo N; the first eligible requester wins.
// Ports:
//   i_eligible : N-bit mask of requesters allowed to win this cycle
//   i_ptr      : index where the scan starts
//   o_grant    : one-hot winner (all zero when nobody is eligible)
//   o_idx      : binary index of the winner (0 when nobody is eligible)
//   o_any      : high when some requester won
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Walk the N candidates in priority order; the first eligible one sticks
  // because later hits are masked by o_any.
  always_comb begin
    int w_cand;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!o_any && i_eligible[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/hv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// hv_mem_arbiter
// Shares one single-port hypervector memory (combinational read, clocked
// write) between NUM_REQ requesters with round-robin arbitration and a
// bounded exclusive lock for read-modify-write sequences.
// Ports:
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   req_valid     : per-requester access request
//   req_we        : per-requester write (1) / read (0)
//   req_lock      : per-requester request/hold of exclusive ownership
//   req_addr      : packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata     : packed write data, same packing
//   req_ready     : one-hot same-cycle grant
//   rsp_valid     : one-hot pulse marking rsp_rdata for a requester
//   rsp_rdata     : registered read data, held until the next read transfer
//   lock_timeout  : one-cycle pulse after a forced lock release
//   mem_address   : memory address
//   mem_we        : memory write enable
//   mem_data_in   : memory write data
//   mem_data_out  : memory combinational read data
// -----------------------------------------------------------------------------
module hv_mem_arbiter
  import hd_mem_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LOCK_MAX   = DEF_LOCK_MAX
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          lock_timeout,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic                          mem_we,
  output logic [DATA_WIDTH-1:0]         mem_data_in,
  input  logic [DATA_WIDTH-1:0]         mem_data_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOCK_MAX + 1);
  // Last LOCKED count before a forced release (acquiring cycle counts as 1).
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);

  arb_state_e          r_state, w_state_nxt;
  logic [IW-1:0]       r_owner, w_owner_nxt;
  logic [CW-1:0]       r_lock_cnt, w_lock_cnt_nxt;
  logic [IW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic                w_timeout_nxt;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                r_lock_timeout;

  logic [NUM_REQ-1:0]  w_owner_mask;
  logic [NUM_REQ-1:0]  w_eligible;
  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic [IW-1:0]       w_pick_idx;
  logic                w_pick_any;
  logic                w_grant;

  function automatic logic [IW-1:0] wrapInc(input logic [IW-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + IW'(1);
  endfunction

  // While locked only the owner may win; the round-robin pointer is irrelevant
  // then because the mask has at most one bit set.
  assign w_owner_mask = NUM_REQ'(1) << r_owner;
  assign w_eligible   = (r_state == LOCKED) ? (req_valid & w_owner_mask) : req_valid;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_eligible (w_eligible),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_pick_onehot),
    .o_idx      (w_pick_idx),
    .o_any      (w_pick_any)
  );

  // Gating with rst_n makes grants and writes vanish the instant reset asserts.
  assign w_grant   = w_pick_any & rst_n;
  assign req_ready = w_grant ? w_pick_onehot : '0;

  // Memory-side mux: winner's request, or all zeros when idle.
  always_comb begin
    mem_address = '0;
    mem_we      = 1'b0;
    mem_data_in = '0;
    if (w_grant) begin
      mem_address = req_addr[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_we      = req_we[w_pick_idx];
      mem_data_in = req_wdata[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // FSM state register together with owner, lock counter and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ARB;
      r_owner        <= '0;
      r_lock_cnt     <= '0;
      r_rr_ptr       <= '0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_owner        <= w_owner_nxt;
      r_lock_cnt     <= w_lock_cnt_nxt;
      r_rr_ptr       <= w_rr_ptr_nxt;
      r_lock_timeout <= w_timeout_nxt;
    end
  end

  // Next-state logic. A locking grant leaves the pointer alone so that the
  // release (voluntary or forced) can move it past the owner instead.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = r_lock_cnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      ARB: begin
        if (w_grant) begin
          if (req_lock[w_pick_idx]) begin
            w_state_nxt    = LOCKED;
            w_owner_nxt    = w_pick_idx;
            w_lock_cnt_nxt = CW'(1);
          end else begin
            w_rr_ptr_nxt = wrapInc(w_pick_idx);
          end
        end
      end
      LOCKED: begin
        if (!req_lock[r_owner]) begin
          w_state_nxt    = ARB;
          w_rr_ptr_nxt   = wrapInc(r_owner);
          w_lock_cnt_nxt = '0;
        end else if (r_lock_cnt == LOCK_LAST) begin
          w_state_nxt    = ARB;
          w_rr_ptr_nxt   = wrapInc(r_owner);
          w_lock_cnt_nxt = '0;
          w_timeout_nxt  = 1'b1;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // Read responses: capture the combinational memory data at the transfer edge.
  // Writes produce no response and leave the held read data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_grant && !req_we[w_pick_idx]) begin
        r_rsp_valid <= w_pick_onehot;
        r_rsp_rdata <= mem_data_out;
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_hv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hv_mem_arbiter
// Directed, table-driven bench for hv_mem_arbiter with a simple behavioural
// memory (combinational read, clocked write) hanging off the memory port.
// -----------------------------------------------------------------------------
module tb_hv_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid, req_we, req_lock;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_ready, rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         lock_timeout;
  logic [7:0]   mem_address;
  logic         mem_we;
  logic [31:0]  mem_data_in, mem_data_out;

  logic [31:0]  mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   valid, we, lock;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   expReady;
    logic         expWe;
    logic [7:0]   expAddr;
    logic [31:0]  expDin;
    logic [3:0]   expRspValid;
    logic [31:0]  expRdata;
    logic         expTimeout;
  } vec_t;

  vec_t vecs[$];

  hv_mem_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .LOCK_MAX(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_lock     (req_lock),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .lock_timeout (lock_timeout),
    .mem_address  (mem_address),
    .mem_we       (mem_we),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Clock generator, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory seen by the arbiter.
  assign mem_data_out = mem[mem_address];
  always @(posedge clk) if (mem_we) mem[mem_address] <= mem_data_in;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] we, input logic [3:0] lk,
                               input logic [31:0] a, input logic [127:0] d);
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic addVec(input logic [3:0] v, input logic [3:0] we, input logic [3:0] lk,
                        input logic [31:0] a, input logic [127:0] d,
                        input logic [3:0] eR, input logic eW, input logic [7:0] eA,
                        input logic [31:0] eD, input logic [3:0] eRv,
                        input logic [31:0] eRd, input logic eTo);
    vec_t t;
    t.valid = v; t.we = we; t.lock = lk; t.addr = a; t.wdata = d;
    t.expReady = eR; t.expWe = eW; t.expAddr = eA; t.expDin = eD;
    t.expRspValid = eRv; t.expRdata = eRd; t.expTimeout = eTo;
    vecs.push_back(t);
  endtask

  localparam logic [31:0] STD_ADDR = 32'h43424140;

  initial begin
    logic [31:0] lockAddr;
    logic [127:0] wd;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h05] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) mem[8'h40 + i] = 32'h10000000 + i;

    rst_n = 1'b0;
    applyStimulus(4'b0, 4'b0, 4'b0, 32'h0, 128'h0);

    // Reset state, with a request present to show the grant is suppressed.
    @(negedge clk);
    applyStimulus(4'b1111, 4'b1111, 4'b0, STD_ADDR, 128'h0);
    #1;
    checkOutput("reset_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_timeout", 32'(lock_timeout), 32'h0);
    @(negedge clk);
    applyStimulus(4'b0, 4'b0, 4'b0, 32'h0, 128'h0);
    rst_n = 1'b1;

    lockAddr = 32'h43421040;
    // Single read of 0x05, then park the pointer back at 0 via requester 3.
    addVec(4'b0001, 4'b0, 4'b0, 32'h43424105, 128'h0, 4'b0001, 1'b0, 8'h05, 32'h0, 4'b0001, 32'hDEADBEEF, 1'b0);
    addVec(4'b1000, 4'b0, 4'b0, STD_ADDR, 128'h0, 4'b1000, 1'b0, 8'h43, 32'h0, 4'b1000, 32'h10000003, 1'b0);
    // Round robin across all four requesters, twice around.
    for (int k = 0; k < 8; k++)
      addVec(4'b1111, 4'b0, 4'b0, STD_ADDR, 128'h0, 4'(1 << (k % 4)), 1'b0, 8'(8'h40 + k % 4), 32'h0,
             4'(1 << (k % 4)), 32'h10000000 + 32'(k % 4), 1'b0);
    // Move the pointer to requester 1.
    addVec(4'b0001, 4'b0, 4'b0, STD_ADDR, 128'h0, 4'b0001, 1'b0, 8'h40, 32'h0, 4'b0001, 32'h10000000, 1'b0);
    // Requester 1 locks: read 0x10, write 7 to 0x10, then drop the lock idle.
    addVec(4'b1111, 4'b0, 4'b0010, lockAddr, 128'h0, 4'b0010, 1'b0, 8'h10, 32'h0, 4'b0010, 32'h0, 1'b0);
    addVec(4'b1111, 4'b0010, 4'b0010, lockAddr, 128'h7 << 32, 4'b0010, 1'b1, 8'h10, 32'h7, 4'b0000, 32'h0, 1'b0);
    addVec(4'b1101, 4'b0, 4'b0, lockAddr, 128'h0, 4'b0000, 1'b0, 8'h00, 32'h0, 4'b0000, 32'h0, 1'b0);
    // Next grant must go to requester 2, which reads back the locked write.
    addVec(4'b1101, 4'b0, 4'b0, 32'h43101040, 128'h0, 4'b0100, 1'b0, 8'h10, 32'h0, 4'b0100, 32'h7, 1'b0);
    // Back-to-back write then read of the same address by requester 0.
    addVec(4'b0001, 4'b0001, 4'b0, 32'h43424120, 128'hA5A5A5A5, 4'b0001, 1'b1, 8'h20, 32'hA5A5A5A5, 4'b0000, 32'h7, 1'b0);
    addVec(4'b0001, 4'b0, 4'b0, 32'h43424120, 128'h0, 4'b0001, 1'b0, 8'h20, 32'h0, 4'b0001, 32'hA5A5A5A5, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].valid, vecs[i].we, vecs[i].lock, vecs[i].addr, vecs[i].wdata);
      #1;
      checkOutput($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].expReady));
      checkOutput($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].expWe));
      checkOutput($sformatf("v%0d_mem_addr", i), 32'(mem_address), 32'(vecs[i].expAddr));
      checkOutput($sformatf("v%0d_mem_din", i), mem_data_in, vecs[i].expDin);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].expRspValid));
      checkOutput($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d_timeout", i), 32'(lock_timeout), 32'(vecs[i].expTimeout));
    end

    // Forced release: pointer is at 1, requesters 2 (locking) and 3 contend.
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      applyStimulus(4'b1100, 4'b0, 4'b0100, STD_ADDR, 128'h0);
      #1;
      checkOutput($sformatf("lock_c%0d_ready", c), 32'(req_ready), 32'h4);
      checkOutput($sformatf("lock_c%0d_timeout", c), 32'(lock_timeout), 32'h0);
    end
    @(negedge clk);
    #1;
    checkOutput("timeout_ready", 32'(req_ready), 32'h8);
    checkOutput("timeout_pulse", 32'(lock_timeout), 32'h1);
    checkOutput("timeout_rdata", rsp_rdata, 32'h10000002);
    @(negedge clk);
    #1;
    checkOutput("relock_ready", 32'(req_ready), 32'h4);
    checkOutput("timeout_cleared", 32'(lock_timeout), 32'h0);
    checkOutput("relock_rsp_valid", 32'(rsp_valid), 32'h8);

    // Reset mid-lock while requester 2 is writing and a response is pending.
    @(negedge clk);
    wd = 128'hBAD << 64;
    applyStimulus(4'b1100, 4'b0100, 4'b0100, STD_ADDR, wd);
    #1;
    checkOutput("prerst_mem_we", 32'(mem_we), 32'h1);
    checkOutput("prerst_rsp_valid", 32'(rsp_valid), 32'h4);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rdata", rsp_rdata, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_no_write", mem[8'h42], 32'h10000002);
    @(negedge clk);
    applyStimulus(4'b1111, 4'b0, 4'b0, STD_ADDR, 128'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("postrst_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("postrst_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("postrst_rdata", rsp_rdata, 32'h10000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
